// File: rtl/credit_display_ctrl.sv
// Binary credit value to four BCD digits via sequential double-dabble, plus a
// time-multiplexed digit scanner with leading-zero blanking for the 7-seg decoder.
module credit_display_ctrl #(
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic [15:0]      bcd_value,
  output logic [3:0]       bcd_digit,
  output logic [3:0]       an
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned MAX_VAL = 9999;

  typedef enum logic {StIdle, StConv} state_e;

  state_e      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] scratch_q, scratch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] value_q, value_d;
  logic [15:0] adj;
  logic        in_range;
  logic [BIN_W-1:0] clamped;

  assign in_range = (bin_in <= BIN_W'(MAX_VAL));
  assign clamped  = in_range ? bin_in : BIN_W'(MAX_VAL);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    value_d   = value_q;
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                     : scratch_q[4*i +: 4];
    end
    unique case (state_q)
      StIdle: begin
        if (load) begin
          bin_d     = clamped[13:0];
          scratch_d = '0;
          cnt_d     = '0;
          ovf_d     = !in_range;
          state_d   = StConv;
        end
      end
      StConv: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d              = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          value_d = scratch_d;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      value_q   <= value_d;
    end
  end

  // Digit scanner: always reads the held result, never the scratch register.
  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q, idx_next;
  logic [3:0]       an_q, digit_q;
  logic [3:0]       shown [4];
  logic             lead;
  logic             wrap;

  assign wrap     = (div_q == DIV_W'(SCAN_DIV - 1));
  assign idx_next = idx_q + 2'd1;

  always_comb begin
    lead     = 1'b1;
    shown[0] = value_q[3:0];
    for (int i = 3; i >= 1; i--) begin
      shown[i] = value_q[4*i +: 4];
      if (lead && value_q[4*i +: 4] == 4'd0) begin
        shown[i] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1110;
      digit_q <= 4'h0;
    end else if (wrap) begin
      div_q   <= '0;
      idx_q   <= idx_next;
      an_q    <= ~(4'b0001 << idx_next);
      digit_q <= shown[idx_next];
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  assign busy      = (state_q == StConv);
  assign ovf       = ovf_q;
  assign bcd_value = value_q;
  assign bcd_digit = digit_q;
  assign an        = an_q;

endmodule

// File: doc/credit_display_ctrl.md
Name: credit_display_ctrl

Overview:
- Upstream driver for the BCD-to-seven-segment decoder in the vending machine's credit/price display.
- Converts a binary credit value (0..9999) to four BCD digits using a sequential double-dabble converter, one shift per clock.
- Time-multiplexes the four digits onto a single 4-bit BCD bus, with active-low digit enables.
- Leading zeros are blanked by emitting code 4'hF, which the decoder renders as all segments off.

Parameters:
- BIN_W, 14, width of the binary input (14 bits covers 9999).
- SCAN_DIV, 50000, clock cycles each digit stays active. Legal range is 1 or greater.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bin_in  input  BIN_W  binary value to display. Sampled only when load is accepted.
- load  input  1  single-cycle request to convert bin_in. Accepted only while idle.
- busy  output  1  high while a conversion is in progress.
- ovf  output  1  high when the last accepted bin_in exceeded 9999.
- bcd_value  output  16  converted digits {thousands, hundreds, tens, units}, held between conversions.
- bcd_digit  output  4  digit currently scanned. Goes to the decoder input.
- an  output  4  active-low one-hot digit enable. an[0] selects units, an[3] selects thousands.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, busy=0, ovf=0, bcd_value=16'h0000
  - scan index=0, divider=0, an=4'b1110, bcd_digit=4'h0
- FSM states are IDLE and CONV.
- IDLE behaviour:
  - When load=1 at edge E0, capture min(bin_in, 9999) into the shift register.
  - Clear the BCD scratch register and set shift count=0.
  - ovf <= (bin_in > 9999).
  - Go to CONV; busy=1 after E0.
- CONV behaviour, each edge E1..E14:
  - For each scratch nibble >= 5, add 3.
  - Then shift {scratch, bin} left by 1.
  - On the 14th shift (E14): bcd_value <= final scratch, busy <= 0, go to IDLE.
  - Result is visible, and a new load can be accepted, from the cycle after E14. busy is high for exactly 14 cycles.
- load while busy=1 is ignored. It is not queued, and ovf is unchanged.
- bin_in changing during CONV has no effect.
- The display always shows the held bcd_value (double-buffered), so it never shows partial results.
- Scan divider behaviour:
  - The divider counts 0..SCAN_DIV-1.
  - On wrap, the scan index advances 0->1->2->3->0 and the divider restarts at 0.
  - With SCAN_DIV=1 the index advances every cycle.
- an and bcd_digit are registered and update on the same edge as the index. an = ~(1 << index).
- Blanking rules:
  - A digit is blanked (bcd_digit=4'hF) if it and every more-significant digit are zero.
  - The units digit is never blanked.
  - Interior zeros are shown.
- A new bcd_value takes effect on the next digit update. The scan position is not reset by load.
- Reset asserted mid-conversion aborts it:
  - All outputs return to their reset values.
  - A load sampled while rst=1 is discarded.

Test Plan:
- Reset, then load bin_in=1234:
  - busy is high for 14 cycles, then bcd_value=16'h1234, ovf=0.
  - Over the scan, an=1110/1101/1011/0111 pairs with bcd_digit=4/3/2/1.
- Load 105 -> bcd_value=16'h0105. Scanned digits are 5, 0, 1, F: the interior zero is shown and the thousands digit is blanked.
- Load 0, then load 9999:
  - For 0, digits are 0, F, F, F.
  - For 9999, bcd_value=16'h9999 and all four digits show 9.
- Load 12000 -> ovf=1 and bcd_value=16'h9999. A subsequent load of 7 clears ovf and gives bcd_value=16'h0007.
- Load 1234, then pulse load with 4321 on cycle 5 of busy:
  - The second load is ignored; the result is 16'h1234.
  - A load of 4321 after busy falls gives 16'h4321.
- Load 5678, assert rst on cycle 7 of busy:
  - Immediately busy=0, bcd_value=0, an=1110, bcd_digit=0.
  - After rst is released, a load of 42 converts normally.
- With SCAN_DIV=3, each an pattern is held exactly 3 cycles.
